// File: rtl/delay_tap_reader.sv
// delay_tap_reader: circular-buffer delay line with a handshaked arbitrary-delay tap read port
module delay_tap_reader #(
    parameter int WIDTH = 12,
    parameter int LEN = 2048,
    localparam int AW = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_delay,
    output logic             rd_busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_err,
    output logic [AW:0]      fill
);
    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
    state_t           state_q, state_d;
    logic [AW-1:0]    wp_q, addr_q, addr_d;
    logic [AW:0]      fill_q;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem [LEN];
    logic [WIDTH-1:0] rdata_q;

    // write pointer advances and fill saturates at LEN on each strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            fill_q <= '0;
        end else if (enable) begin
            wp_q   <= wp_q + AW'(1);
            fill_q <= fill_q + (AW+1)'(fill_q != (AW+1)'(LEN));
        end
    end

    // block RAM: write port plus a read port that registers only in FETCH so the response holds
    always_ff @(posedge clk) begin
        if (enable) mem[wp_q] <= in;
        if (state_q == FETCH) rdata_q <= mem[addr_q];
    end

    // read FSM state, captured tap address and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // next state, request capture from pre-write pointer/fill, and response outputs
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (rd_req) begin
                addr_d  = wp_q - rd_delay;
                err_d   = (rd_delay == '0) || ({1'b0, rd_delay} > fill_q);
                state_d = FETCH;
            end
            FETCH:   state_d = RESP;
            RESP:    state_d = rd_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        rd_busy  = state_q != IDLE;
        rd_valid = state_q == RESP;
        rd_err   = rd_valid && err_q;
        rd_data  = (rd_valid && !err_q) ? rdata_q : '0;
        fill     = fill_q;
    end
endmodule

// File: tb/tb_delay_tap_reader.sv
// tb_delay_tap_reader: directed checks of the delay tap reader with an 8-deep buffer
module tb_delay_tap_reader;
    localparam int W = 12;
    localparam int L = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] in = '0;
    logic         rd_req = 1'b0;
    logic [A-1:0] rd_delay = '0;
    logic         rd_busy, rd_valid, rd_ready, rd_err;
    logic [W-1:0] rd_data;
    logic [A:0]   fill;
    int           errors = 0;
    int           checks = 0;

    delay_tap_reader #(.WIDTH(W), .LEN(L)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in(in),
        .rd_req(rd_req), .rd_delay(rd_delay), .rd_busy(rd_busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_err(rd_err), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] v);
        enable = 1'b1;
        in = v;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic req(input logic [A-1:0] d, input logic [W-1:0] ed, input logic ee);
        rd_delay = d;
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        chk("accept_busy", rd_busy, 1);
        chk("fetch_no_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        chk("resp_valid", rd_valid, 1);
        chk("resp_data", rd_data, ed);
        chk("resp_err", rd_err, ee);
        @(posedge clk);
        #1;
        chk("done_valid", rd_valid, 0);
        chk("done_busy", rd_busy, 0);
    endtask

    initial begin
        rd_ready = 1'b1;
        #1;
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", rd_busy, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_err", rd_err, 0);
        chk("rst_fill", fill, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 1; i <= 5; i++) push(W'(i));
        chk("fill5", fill, 5);
        req(3'd1, 12'd5, 1'b0);
        req(3'd5, 12'd1, 1'b0);
        req(3'd3, 12'd3, 1'b0);
        req(3'd0, 12'd0, 1'b1);
        req(3'd6, 12'd0, 1'b1);

        do_reset();
        push(12'd7);
        push(12'd8);
        push(12'd9);
        chk("fill3", fill, 3);
        req(3'd4, 12'd0, 1'b1);
        req(3'd3, 12'd7, 1'b0);
        req(3'd0, 12'd0, 1'b1);

        do_reset();
        for (int i = 0; i < 12; i++) push(W'(i));
        chk("fill_sat", fill, 8);
        req(3'd7, 12'd5, 1'b0);
        req(3'd1, 12'd11, 1'b0);
        req(3'd4, 12'd8, 1'b0);

        do_reset();
        push(12'd10);
        push(12'd20);
        push(12'd30);
        rd_ready = 1'b0;
        enable = 1'b1;
        in = 12'd99;
        rd_delay = 3'd2;
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        in = 12'd55;
        chk("same_cycle_busy", rd_busy, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            enable = i[0] ? 1'b0 : 1'b1;
            in = W'(200 + i);
            rd_req = i[0];
            rd_delay = 3'd1;
            chk("hold_valid", rd_valid, 1);
            chk("hold_data", rd_data, 20);
            chk("hold_err", rd_err, 0);
            chk("hold_busy", rd_busy, 1);
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        rd_req = 1'b0;
        chk("hold_last_data", rd_data, 20);
        chk("fill_after_hold", fill, 8);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_valid_fall", rd_valid, 0);
        chk("ready_busy_fall", rd_busy, 0);
        @(posedge clk);
        #1;
        chk("no_queued_req", rd_busy, 0);
        req(3'd1, 12'd208, 1'b0);

        do_reset();
        push(12'd42);
        push(12'd43);
        rd_delay = 3'd1;
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        chk("pre_abort_busy", rd_busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", rd_busy, 0);
        chk("abort_valid", rd_valid, 0);
        chk("abort_data", rd_data, 0);
        chk("abort_err", rd_err, 0);
        chk("abort_fill", fill, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_abort_valid", rd_valid, 0);
            @(posedge clk);
            #1;
        end
        req(3'd1, 12'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
